hpdcache_l15_resp_router: RTL and testbench

//  Response-routing stage that feeds the L1.5 response demultiplexer.
//  - Records which requester port issued each outstanding memory transaction ID.
//  - On each response, looks up the requester port and buffers the response in a 2-entry FIFO.
//  - Presents response + port select to the demux over a valid/ready handshake.
//  - Flags responses whose ID has no outstanding allocation.

---
 rtl/hpdcache_l15_resp_router_if.sv | 42 ++++
 rtl/hpdcache_l15_resp_router.sv | 97 +++++++++
 tb/tb_hpdcache_l15_resp_router.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/hpdcache_l15_resp_router_if.sv
// Handshake bundle between the requester/memory side and the L1.5 response router.
// The router takes the slave modport; the environment driving it takes the master modport.
interface hpdcache_l15_resp_router_if #(
  parameter int N      = 4,
  parameter int ID_W   = 4,
  parameter int RESP_W = 64
);
  localparam int PORT_W = (N > 1) ? $clog2(N) : 1;

  logic              alloc_valid_i;
  logic              alloc_ready_o;
  logic [ID_W-1:0]   alloc_id_i;
  logic [PORT_W-1:0] alloc_portid_i;

  logic              mem_resp_valid_i;
  logic              mem_resp_ready_o;
  logic [RESP_W-1:0] mem_resp_i;
  logic [ID_W-1:0]   mem_resp_id_i;
  logic              mem_resp_last_i;

  logic              resp_valid_o;
  logic              resp_ready_i;
  logic [RESP_W-1:0] resp_o;
  logic [PORT_W-1:0] resp_sel_o;
  logic              err_unalloc_o;

  modport slave (
    input  alloc_valid_i, alloc_id_i, alloc_portid_i,
    input  mem_resp_valid_i, mem_resp_i, mem_resp_id_i, mem_resp_last_i,
    input  resp_ready_i,
    output alloc_ready_o, mem_resp_ready_o,
    output resp_valid_o, resp_o, resp_sel_o, err_unalloc_o
  );

  modport master (
    output alloc_valid_i, alloc_id_i, alloc_portid_i,
    output mem_resp_valid_i, mem_resp_i, mem_resp_id_i, mem_resp_last_i,
    output resp_ready_i,
    input  alloc_ready_o, mem_resp_ready_o,
    input  resp_valid_o, resp_o, resp_sel_o, err_unalloc_o
  );
endinterface

// File: rtl/hpdcache_l15_resp_router.sv
// Tracks the requester port owning each outstanding transaction ID and routes
// memory response beats, through a 2-entry FIFO, to the L1.5 response demux.
module hpdcache_l15_resp_router #(
  parameter int N      = 4,
  parameter int ID_W   = 4,
  parameter int RESP_W = 64
) (
  input logic clk_i,
  input logic rst_i,
  hpdcache_l15_resp_router_if.slave bus
);
  localparam int PORT_W = (N > 1) ? $clog2(N) : 1;
  localparam int RT_D   = 2 ** ID_W;

  // Routing table: busy bits are control state, port ids are plain data
  logic [RT_D-1:0]   busy_q, busy_d;
  logic [PORT_W-1:0] portid_q [RT_D];
  logic [PORT_W-1:0] portid_d [RT_D];

  // Response FIFO
  logic [RESP_W-1:0] fifo_data_q [2];
  logic [RESP_W-1:0] fifo_data_d [2];
  logic [PORT_W-1:0] fifo_sel_q  [2];
  logic [PORT_W-1:0] fifo_sel_d  [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              err_q, err_d;

  logic alloc_hs, resp_hs, resp_hit, push, pop;

  // Readies are forced low during reset so nothing is accepted into state being cleared
  assign bus.alloc_ready_o    = ~rst_i & ~busy_q[bus.alloc_id_i];
  assign bus.mem_resp_ready_o = ~rst_i & (cnt_q != 2'd2);

  assign alloc_hs = bus.alloc_valid_i & bus.alloc_ready_o;
  assign resp_hs  = bus.mem_resp_valid_i & bus.mem_resp_ready_o;
  assign resp_hit = busy_q[bus.mem_resp_id_i];
  assign push     = resp_hs & resp_hit;
  assign pop      = bus.resp_valid_o & bus.resp_ready_i;

  assign bus.resp_valid_o  = (cnt_q != 2'd0);
  assign bus.resp_o        = fifo_data_q[rd_ptr_q];
  assign bus.resp_sel_o    = fifo_sel_q[rd_ptr_q];
  assign bus.err_unalloc_o = err_q;

  always_comb begin
    busy_d   = busy_q;
    portid_d = portid_q;
    // A busy ID cannot be re-allocated, so the free and the set never target the same entry
    if (push && bus.mem_resp_last_i) busy_d[bus.mem_resp_id_i] = 1'b0;
    if (alloc_hs) begin
      busy_d[bus.alloc_id_i]   = 1'b1;
      portid_d[bus.alloc_id_i] = bus.alloc_portid_i;
    end
  end

  always_comb begin
    fifo_data_d = fifo_data_q;
    fifo_sel_d  = fifo_sel_q;
    if (push) begin
      fifo_data_d[wr_ptr_q] = bus.mem_resp_i;
      fifo_sel_d[wr_ptr_q]  = portid_q[bus.mem_resp_id_i];
    end
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
    err_d = err_q | (resp_hs & ~resp_hit);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      err_q    <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  // Payload storage needs no reset: it is only observed behind valid/busy bits
  always_ff @(posedge clk_i) begin
    portid_q    <= portid_d;
    fifo_data_q <= fifo_data_d;
    fifo_sel_q  <= fifo_sel_d;
  end
endmodule

// File: tb/tb_hpdcache_l15_resp_router.sv
// Randomised plus directed bench for the L1.5 response router with a queue-based
// reference model and a separate output monitor.
module tb_hpdcache_l15_resp_router;
  localparam int N      = 4;
  localparam int ID_W   = 4;
  localparam int RESP_W = 64;
  localparam int RT_D   = 2 ** ID_W;

  typedef struct {
    logic [RESP_W-1:0] data;
    logic [1:0]        sel;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hpdcache_l15_resp_router_if #(.N(N), .ID_W(ID_W), .RESP_W(RESP_W)) bus ();

  hpdcache_l15_resp_router #(.N(N), .ID_W(ID_W), .RESP_W(RESP_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference state: ownership table, in-flight expectations, buffered beat count, sticky error
  bit   m_busy [RT_D];
  int   m_port [RT_D];
  exp_t exp_q[$];
  int   m_occ = 0;
  bit   m_err = 1'b0;

  task automatic chk(input string name, input logic [RESP_W-1:0] act, input logic [RESP_W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, req, $time);
    end
  endtask

  // Model: compare control outputs, then advance on the handshakes happening at the next edge
  always @(negedge clk) begin
    bit ar, mr, v, a_hs, r_hs;
    ar = !rst && !m_busy[bus.alloc_id_i];
    mr = !rst && (m_occ < 2);
    v  = (m_occ > 0);
    chk("alloc_ready", 64'(bus.alloc_ready_o), 64'(ar));
    chk("mem_resp_ready", 64'(bus.mem_resp_ready_o), 64'(mr));
    chk("resp_valid", 64'(bus.resp_valid_o), 64'(v));
    chk("err_unalloc", 64'(bus.err_unalloc_o), 64'(m_err));
    if (rst) begin
      for (int i = 0; i < RT_D; i++) m_busy[i] = 1'b0;
      exp_q.delete();
      m_occ = 0;
      m_err = 1'b0;
    end else begin
      a_hs = bus.alloc_valid_i && ar;
      r_hs = bus.mem_resp_valid_i && mr;
      if (v && bus.resp_ready_i) m_occ--;
      if (r_hs) begin
        if (m_busy[bus.mem_resp_id_i]) begin
          exp_t e;
          e.data = bus.mem_resp_i;
          e.sel  = 2'(m_port[bus.mem_resp_id_i]);
          exp_q.push_back(e);
          m_occ++;
          if (bus.mem_resp_last_i) m_busy[bus.mem_resp_id_i] = 1'b0;
        end else begin
          m_err = 1'b1;
        end
      end
      if (a_hs) begin
        m_busy[bus.alloc_id_i] = 1'b1;
        m_port[bus.alloc_id_i] = int'(bus.alloc_portid_i);
      end
    end
  end

  // Monitor: whenever a beat leaves the router, match it against the oldest expectation
  always @(negedge clk) begin
    #1;
    if (!rst && bus.resp_valid_o && bus.resp_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat actual=%0h required=none time=%0t", bus.resp_o, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("resp_data", bus.resp_o, e.data);
        chk("resp_sel", 64'(bus.resp_sel_o), 64'(e.sel));
      end
    end
  end

  task automatic cyc(input bit av, input int aid, input int ap,
                     input bit mv, input int mid, input logic [RESP_W-1:0] md,
                     input bit ml, input bit rr);
    bus.alloc_valid_i    = av;
    bus.alloc_id_i       = ID_W'(aid);
    bus.alloc_portid_i   = 2'(ap);
    bus.mem_resp_valid_i = mv;
    bus.mem_resp_id_i    = ID_W'(mid);
    bus.mem_resp_i       = md;
    bus.mem_resp_last_i  = ml;
    bus.resp_ready_i     = rr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit rr);
    for (int i = 0; i < n; i++) cyc(0, i % RT_D, 0, 0, 0, '0, 0, rr);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(1, 1);
    rst = 1'b0;
  endtask

  initial begin
    idle(2, 1);
    rst = 1'b0;
    idle(1, 1);

    // Single-beat routing: id 3 owned by port 2
    cyc(1, 3, 2, 0, 0, '0, 0, 1);
    cyc(0, 0, 0, 1, 3, 64'hA5, 1, 1);
    idle(3, 1);

    // Four back-to-back beats for id 5, port 1
    cyc(1, 5, 1, 0, 0, '0, 0, 1);
    for (int b = 0; b < 4; b++) cyc(0, 0, 0, 1, 5, 64'h5000 + 64'(b), (b == 3), 1);
    idle(3, 1);

    // Backpressure: third beat waits for FIFO space, order preserved
    cyc(1, 6, 3, 0, 0, '0, 0, 0);
    cyc(0, 0, 0, 1, 6, 64'h11, 0, 0);
    cyc(0, 0, 0, 1, 6, 64'h22, 0, 0);
    cyc(0, 0, 0, 1, 6, 64'h33, 1, 0);
    cyc(0, 0, 0, 1, 6, 64'h33, 1, 1);
    cyc(0, 0, 0, 1, 6, 64'h33, 1, 1);
    idle(4, 1);

    // Last-beat free collides with re-allocation of the same id
    cyc(1, 2, 1, 0, 0, '0, 0, 1);
    cyc(1, 2, 3, 1, 2, 64'hC0DE, 1, 1);
    cyc(1, 2, 3, 0, 0, '0, 0, 1);
    cyc(0, 0, 0, 1, 2, 64'hBEEF, 1, 1);
    idle(3, 1);

    // Random traffic, responses only to busy ids
    for (int c = 0; c < 3000; c++) begin
      int busy_ids[$];
      int mid;
      bit mv;
      for (int i = 0; i < RT_D; i++) if (m_busy[i]) busy_ids.push_back(i);
      mv  = (busy_ids.size() != 0) && ($urandom_range(0, 3) != 0);
      mid = (busy_ids.size() != 0) ? busy_ids[$urandom_range(0, busy_ids.size() - 1)] : 0;
      cyc($urandom_range(0, 1), $urandom_range(0, RT_D - 1), $urandom_range(0, N - 1),
          mv, mid, {$urandom, $urandom}, ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0));
    end
    idle(4, 1);

    // Unallocated response: dropped, sticky error until reset
    do_reset();
    cyc(0, 0, 0, 1, 7, 64'hDEAD, 1, 1);
    idle(5, 1);

    // Reset with a full FIFO and several busy ids discards everything
    for (int i = 8; i < 12; i++) cyc(1, i, i % N, 0, 0, '0, 0, 0);
    cyc(0, 0, 0, 1, 8, 64'h88, 0, 0);
    cyc(0, 0, 0, 1, 9, 64'h99, 0, 0);
    idle(1, 0);
    do_reset();
    idle(RT_D, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
